// File: rtl/matrix_keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot-low column drive, synchronized row sense,
// per-scan NONE/SINGLE/MULTI classification and a debounced press/release FSM.
module matrix_keypad_scanner #(
  parameter int SCAN_DIVIDER   = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [3:0] keypad_col,
  input  logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam int              DW         = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIVIDER - 1);
  localparam logic [3:0]      DB_MAX     = 4'(DEBOUNCE_COUNT);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [1:0]    hit_cnt_q;
  logic [3:0]    hit_code_q;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          sample, scan_end;
  logic [1:0]    cur_cnt, cur_row, tot_cnt;
  logic [2:0]    sum_cnt;
  logic [3:0]    tot_code, inc_cnt;
  logic          is_none, is_single, accept, rel_key;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= keypad_row;
      row_sync_q <= row_meta_q;
    end
  end

  assign sample     = (dwell_q == DWELL_LAST);
  assign scan_end   = sample && (col_q == 2'd3);
  assign keypad_col = ~(4'b0001 << col_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
    end else if (sample) begin
      dwell_q <= '0;
      col_q   <= col_q + 2'd1;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // Hit count saturates at 2: anything beyond one pressed sample is MULTI.
  always_comb begin
    cur_cnt = 2'd0;
    cur_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        if (cur_cnt == 2'd0) cur_row = 2'(r);
        if (cur_cnt != 2'd2) cur_cnt = cur_cnt + 2'd1;
      end
    end
    sum_cnt  = {1'b0, hit_cnt_q} + {1'b0, cur_cnt};
    tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    tot_code = (hit_cnt_q != 2'd0) ? hit_code_q : {cur_row, col_q};
  end

  assign is_none   = (tot_cnt == 2'd0);
  assign is_single = (tot_cnt == 2'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= 2'd0;
      hit_code_q <= 4'd0;
    end else if (scan_end) begin
      hit_cnt_q  <= 2'd0;
      hit_code_q <= 4'd0;
    end else if (sample) begin
      hit_cnt_q  <= tot_cnt;
      hit_code_q <= tot_code;
    end
  end

  assign inc_cnt = (cnt_q >= DB_MAX) ? DB_MAX : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    rel_key = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            state_d = PRESS_DB;
            cand_d  = tot_code;
            cnt_d   = 4'd1;
            accept  = (4'd1 >= DB_MAX);
          end
        end
        PRESS_DB: begin
          if (is_single) begin
            cand_d = tot_code;
            cnt_d  = (tot_code == cand_q) ? inc_cnt : 4'd1;
            accept = (cnt_d >= DB_MAX);
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (is_none) begin
            state_d = RELEASE_DB;
            cnt_d   = 4'd1;
            rel_key = (4'd1 >= DB_MAX);
          end
        end
        RELEASE_DB: begin
          if (is_none) begin
            cnt_d   = inc_cnt;
            rel_key = (inc_cnt >= DB_MAX);
          end else begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        state_d = PRESSED;
        code_d  = cand_d;
        valid_d = 1'b1;
        held_d  = 1'b1;
        cnt_d   = 4'd0;
      end
      // key_code deliberately keeps the released key's value.
      if (rel_key) begin
        state_d = IDLE;
        held_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with a behavioural 4x4 keypad model
// (SCAN_DIVIDER=4, DEBOUNCE_COUNT=3, one scan = 16 cycles).
module tb_matrix_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] keypad_col;
  logic [3:0] keypad_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] fsm_state;

  logic [15:0] press_mask = 16'h0000;

  int   n_cmp      = 0;
  int   n_err      = 0;
  int   cyc        = 0;
  int   valid_cnt  = 0;
  int   valid_cyc  = -1;
  int   consec     = 0;
  logic prev_valid = 1'b0;
  logic left_idle  = 1'b0;

  matrix_keypad_scanner #(.SCAN_DIVIDER(SD), .DEBOUNCE_COUNT(DB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .keypad_col (keypad_col),
    .keypad_row (keypad_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .fsm_state  (fsm_state)
  );

  always #5 clock = ~clock;

  // Pressed key (r,c) shorts row r to column c; rows are pulled up otherwise.
  always_comb begin
    keypad_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !keypad_col[c]) keypad_row[r] = 1'b0;
  end

  task automatic clear_stats();
    valid_cnt  = 0;
    valid_cyc  = -1;
    consec     = 0;
    prev_valid = 1'b0;
    left_idle  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    clear_stats();
  endtask

  task automatic run_scans(input int n, input logic [15:0] mask);
    press_mask = mask;
    repeat (n * SCAN) begin
      @(posedge clock);
      #1;
      cyc++;
      if (key_valid) begin
        if (prev_valid) consec++;
        valid_cnt++;
        valid_cyc = cyc;
      end
      prev_valid = key_valid;
      if (fsm_state != 2'd0) left_idle = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    press_mask = 16'h0000;
    #2;
    n_cmp++; if (keypad_col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b expected 1110", keypad_col); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    n_cmp++; if ({key_valid, key_held} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {key_valid, key_held}); end
    n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    apply_reset();
  endtask

  task automatic test_sweep();
    logic [3:0] exp_col;
    apply_reset();
    press_mask = 16'h0000;
    for (int t = 0; t <= 2 * SCAN; t++) begin
      if (t > 0) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      exp_col = 4'b1111;
      exp_col[(t / SD) % 4] = 1'b0;
      n_cmp++;
      if ({keypad_col, key_held, key_valid} !== {exp_col, 2'b00}) begin
        n_err++;
        $display("FAIL sweep_t%0d: got col=%b held=%b valid=%b expected col=%b held=0 valid=0",
                 t, keypad_col, key_held, key_valid, exp_col);
      end
    end
  endtask

  task automatic test_single_press();
    apply_reset();
    run_scans(5, 16'h0200);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt); end
    n_cmp++; if (valid_cyc !== 3 * SCAN) begin n_err++; $display("FAIL single_valid_cycle: got %0d expected %0d", valid_cyc, 3 * SCAN); end
    n_cmp++; if (key_code !== 4'd9) begin n_err++; $display("FAIL single_code: got %0d expected 9", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL single_held: got %b expected 1", key_held); end
    run_scans(2, 16'h0000);
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL single_held_2none: got %b expected 1", key_held); end
    run_scans(1, 16'h0000);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL single_released: got %b expected 0", key_held); end
    n_cmp++; if (key_code !== 4'd9) begin n_err++; $display("FAIL single_code_kept: got %0d expected 9", key_code); end
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL single_no_release_pulse: got %0d expected 1", valid_cnt); end
    n_cmp++; if (consec !== 0) begin n_err++; $display("FAIL single_valid_consecutive: got %0d expected 0", consec); end
  endtask

  task automatic test_bounce();
    apply_reset();
    run_scans(2, 16'h0020);
    run_scans(1, 16'h0000);
    run_scans(3, 16'h0020);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL bounce_valid_count: got %0d expected 1", valid_cnt); end
    n_cmp++; if (valid_cyc !== 6 * SCAN) begin n_err++; $display("FAIL bounce_valid_cycle: got %0d expected %0d", valid_cyc, 6 * SCAN); end
    n_cmp++; if (key_code !== 4'd5) begin n_err++; $display("FAIL bounce_code: got %0d expected 5", key_code); end
  endtask

  task automatic test_ghost();
    apply_reset();
    run_scans(6, 16'h8001);
    n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL ghost_valid_count: got %0d expected 0", valid_cnt); end
    n_cmp++; if (left_idle !== 1'b0) begin n_err++; $display("FAIL ghost_left_idle: got %b expected 0", left_idle); end
    run_scans(2, 16'h0001);
    n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL ghost_early_valid: got %0d expected 0", valid_cnt); end
    run_scans(1, 16'h0001);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL ghost_accept_count: got %0d expected 1", valid_cnt); end
    n_cmp++; if (valid_cyc !== 9 * SCAN) begin n_err++; $display("FAIL ghost_accept_cycle: got %0d expected %0d", valid_cyc, 9 * SCAN); end
    n_cmp++; if ({key_code, key_held} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL ghost_code_held: got code=%0d held=%b expected code=0 held=1", key_code, key_held); end
  endtask

  task automatic test_roll();
    apply_reset();
    run_scans(3, 16'h0008);
    n_cmp++; if ({valid_cnt, key_code} !== {32'd1, 4'd3}) begin n_err++; $display("FAIL roll_first: got count=%0d code=%0d expected count=1 code=3", valid_cnt, key_code); end
    run_scans(1, 16'h0088);
    run_scans(2, 16'h0080);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL roll_no_second_valid: got %0d expected 1", valid_cnt); end
    n_cmp++; if ({key_code, key_held} !== {4'd3, 1'b1}) begin n_err++; $display("FAIL roll_held: got code=%0d held=%b expected code=3 held=1", key_code, key_held); end
    run_scans(3, 16'h0000);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL roll_released: got %b expected 0", key_held); end
    run_scans(2, 16'h0080);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL roll_early_valid: got %0d expected 1", valid_cnt); end
    run_scans(1, 16'h0080);
    n_cmp++; if (valid_cnt !== 2) begin n_err++; $display("FAIL roll_second_count: got %0d expected 2", valid_cnt); end
    n_cmp++; if (valid_cyc !== 12 * SCAN) begin n_err++; $display("FAIL roll_second_cycle: got %0d expected %0d", valid_cyc, 12 * SCAN); end
    n_cmp++; if (key_code !== 4'd7) begin n_err++; $display("FAIL roll_second_code: got %0d expected 7", key_code); end
  endtask

  task automatic test_reset_mid();
    run_scans(3, 16'h0000);
    n_cmp++; if ({key_code, key_held} !== {4'd7, 1'b0}) begin n_err++; $display("FAIL rmid_pre: got code=%0d held=%b expected code=7 held=0", key_code, key_held); end
    clear_stats();
    run_scans(2, 16'h1000);
    n_cmp++; if (fsm_state !== 2'd1) begin n_err++; $display("FAIL rmid_press_db: got %0d expected 1", fsm_state); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (keypad_col !== 4'b1110) begin n_err++; $display("FAIL rmid_col: got %b expected 1110", keypad_col); end
    n_cmp++; if ({key_code, key_valid, key_held} !== 6'd0) begin n_err++; $display("FAIL rmid_outputs: got code=%0d valid=%b held=%b expected 0/0/0", key_code, key_valid, key_held); end
    n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rmid_state: got %0d expected 0", fsm_state); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    clear_stats();
    run_scans(2, 16'h1000);
    n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL rmid_early_valid: got %0d expected 0", valid_cnt); end
    run_scans(1, 16'h1000);
    n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL rmid_valid_count: got %0d expected 1", valid_cnt); end
    n_cmp++; if (valid_cyc !== 3 * SCAN) begin n_err++; $display("FAIL rmid_valid_cycle: got %0d expected %0d", valid_cyc, 3 * SCAN); end
    n_cmp++; if (key_code !== 4'd12) begin n_err++; $display("FAIL rmid_code: got %0d expected 12", key_code); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single_press();
    test_bounce();
    test_ghost();
    test_roll();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 Parameter SCAN_DIVIDER, default 50000: clock cycles each column stays driven; legal range 4 and up.
REQ-002 Parameter DEBOUNCE_COUNT, default 4: consecutive identical full-scan results needed to accept a press or a release; legal range 1-15.
REQ-003 clock  input  1  single clock for all logic; rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 keypad_col  output  4  column drive, active-low, one-hot-low (exactly one bit 0 at a time).
REQ-006 keypad_row  input  4  row sense, active-low, externally pulled up, asynchronous to clock.
REQ-007 key_code  output  4  code of the last accepted key = row_index*4 + col_index.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high from acceptance until release is accepted.

Function
REQ-010 keypad_row passes through a 2-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-011 A column index counts 0,1,2,3 and wraps to 0; keypad_col[i]=0 exactly when index=i.
REQ-012 A dwell counter advances the column index every SCAN_DIVIDER cycles.
REQ-013 Synchronized rows are sampled on the last dwell cycle of each column; a row reads as pressed when its bit is 0.
REQ-014 One full scan is 4 columns, i.e. 4*SCAN_DIVIDER cycles, and ends when column 3 is sampled.
REQ-015 Each scan result is one of three kinds:
  - NONE: no pressed samples.
  - SINGLE(code): exactly one pressed sample.
  - MULTI: two or more pressed samples. MULTI is never accepted as a key (anti-ghosting).
REQ-016 The FSM has four states: IDLE, PRESS_DB, PRESSED, RELEASE_DB. Transitions are evaluated only at scan end.
REQ-017 IDLE: SINGLE(c) -> PRESS_DB with candidate=c and count=1. NONE or MULTI -> stay in IDLE.
REQ-018 PRESS_DB behaviour:
  - SINGLE(same candidate): count+1.
  - SINGLE(different code): reload candidate, count=1.
  - NONE or MULTI: -> IDLE.
  - When count reaches DEBOUNCE_COUNT: -> PRESSED, key_code=candidate, key_valid pulses for 1 cycle, key_held=1.
REQ-019 DEBOUNCE_COUNT=1: the first SINGLE result is accepted at that same scan end.
REQ-020 PRESSED: NONE -> RELEASE_DB with count=1. SINGLE (any code) or MULTI -> stay in PRESSED. A new key is never reported while one is held.
REQ-021 RELEASE_DB behaviour:
  - NONE: count+1.
  - SINGLE or MULTI: -> PRESSED.
  - When count reaches DEBOUNCE_COUNT: -> IDLE, key_held=0. key_code holds its value; no pulse is generated.
REQ-022 key_valid and the key_held rise are registered: both appear on the cycle after the accepting scan-end sample.
REQ-023 The debounce count saturates at DEBOUNCE_COUNT and never wraps.
REQ-024 key_valid is never high on two consecutive cycles.

Reset
REQ-025 While reset_n=0, all outputs and state take these values immediately, regardless of clock:
  - keypad_col=4'b1110 (column 0 driven).
  - key_code=0, key_valid=0, key_held=0.
  - FSM=IDLE.
  - dwell counter, column index, debounce count and synchronizer flops all 0 or idle.
REQ-026 Reset asserted mid-press or mid-debounce discards the press; no key_valid is produced.
REQ-027 After reset_n rises, scanning restarts at column 0 with a full SCAN_DIVIDER dwell.

Verification (SCAN_DIVIDER=4, DEBOUNCE_COUNT=3, one scan = 16 cycles)
REQ-028 Single press: row 2 held low only while column 1 is driven, for 5 scans -> key_valid pulses once, key_code=9, key_held=1; after the rows are released, key_held=0 after 3 NONE scans.
REQ-029 Bounce: key code 5 pressed for 2 scans, released for 1 scan, pressed for 3 scans -> exactly one key_valid, issued at the end of the 5th press scan overall (3rd consecutive), key_code=5.
REQ-030 Ghost: codes 0 and 15 held together for 6 scans -> key_valid never asserts and FSM stays in IDLE. Then 15 is released with 0 still held -> key_code=0 after 3 scans.
REQ-031 Hold and roll: code 3 accepted, then code 7 added and 3 removed without an intervening NONE scan -> no second key_valid. After a full release (3 NONE scans) followed by code 7 held for 3 scans -> key_valid, key_code=7.
REQ-032 Reset mid-debounce: key code 12 held for 2 scans, then reset_n pulled low for 3 cycles -> all outputs at reset values immediately and keypad_col=1110. Key still held after reset -> key_valid only after 3 fresh scans.
REQ-033 Scan sweep: no key pressed for 2 scans -> keypad_col cycles 1110, 1101, 1011, 0111, each for exactly 4 cycles, with key_held=0 and key_valid=0 throughout.
